// File: rtl/axi4lite_txn_slice.sv
// Generic synchronous FIFO with wrap-bit pointers used for every slice channel.
// Latency: 1 cycle from enqueue to visible head; head data reads 0 while empty.
// Backpressure: wr_ready = !full (a same-cycle dequeue does not free a full FIFO); rd_valid = !empty.
module axi4lite_txn_slice_fifo #(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [width-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);
  localparam int idxWidth = $clog2(depth);
  typedef logic [idxWidth:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [width-1:0] mem [depth];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (wr_ptr[idxWidth] != rd_ptr[idxWidth]) &&
                    (wr_ptr[idxWidth-1:0] == rd_ptr[idxWidth-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push     = wr_valid && !full;
  assign pop      = rd_ready && !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[idxWidth-1:0]];

  // Pointer update; reset empties the FIFO and discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[idxWidth-1:0]] <= wr_data;
  end
endmodule

// AXI4-Lite transaction slice: five independent channel FIFOs with per-direction outstanding caps.
// Latency: 1 cycle forward on every channel; full throughput with fifoDepth >= 2.
// Backpressure: readies come only from registered FIFO pointers and outstanding counters.
module axi4lite_txn_slice #(
  parameter int dataWidth      = 32,
  parameter int addrWidth      = 32,
  parameter int fifoDepth      = 2,
  parameter int maxOutstanding = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [addrWidth-1:0]                  s_awaddr,
  input  logic [2:0]                            s_awprot,
  input  logic                                  s_awvalid,
  output logic                                  s_awready,
  input  logic [dataWidth-1:0]                  s_wdata,
  input  logic [dataWidth/8-1:0]                s_wstrb,
  input  logic                                  s_wvalid,
  output logic                                  s_wready,
  output logic [1:0]                            s_bresp,
  output logic                                  s_bvalid,
  input  logic                                  s_bready,
  input  logic [addrWidth-1:0]                  s_araddr,
  input  logic [2:0]                            s_arprot,
  input  logic                                  s_arvalid,
  output logic                                  s_arready,
  output logic [dataWidth-1:0]                  s_rdata,
  output logic [1:0]                            s_rresp,
  output logic                                  s_rvalid,
  input  logic                                  s_rready,
  output logic [addrWidth-1:0]                  m_awaddr,
  output logic [2:0]                            m_awprot,
  output logic                                  m_awvalid,
  input  logic                                  m_awready,
  output logic [dataWidth-1:0]                  m_wdata,
  output logic [dataWidth/8-1:0]                m_wstrb,
  output logic                                  m_wvalid,
  input  logic                                  m_wready,
  input  logic [1:0]                            m_bresp,
  input  logic                                  m_bvalid,
  output logic                                  m_bready,
  output logic [addrWidth-1:0]                  m_araddr,
  output logic [2:0]                            m_arprot,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic [dataWidth-1:0]                  m_rdata,
  input  logic [1:0]                            m_rresp,
  input  logic                                  m_rvalid,
  output logic                                  m_rready,
  output logic [$clog2(maxOutstanding+1)-1:0]   wr_outstanding,
  output logic [$clog2(maxOutstanding+1)-1:0]   rd_outstanding,
  output logic [15:0]                           err_count
);
  localparam int cntWidth = $clog2(maxOutstanding + 1);
  localparam logic [cntWidth-1:0] cntMax = cntWidth'(maxOutstanding);

  logic                           wr_room;
  logic                           rd_room;
  logic                           aw_fifo_ready;
  logic                           ar_fifo_ready;
  logic                           aw_hs;
  logic                           b_hs;
  logic                           ar_hs;
  logic                           r_hs;
  logic [addrWidth+2:0]           aw_head;
  logic [addrWidth+2:0]           ar_head;
  logic [dataWidth+dataWidth/8-1:0] w_head;
  logic [dataWidth+1:0]           r_head;
  logic [1:0]                     err_inc;
  logic [16:0]                    err_sum;

  // The cap is applied on registered counts so s_awready/s_arready stay free of input paths.
  assign wr_room   = (wr_outstanding < cntMax);
  assign rd_room   = (rd_outstanding < cntMax);
  assign s_awready = aw_fifo_ready && wr_room;
  assign s_arready = ar_fifo_ready && rd_room;

  assign aw_hs = s_awvalid && s_awready;
  assign b_hs  = s_bvalid && s_bready;
  assign ar_hs = s_arvalid && s_arready;
  assign r_hs  = s_rvalid && s_rready;

  axi4lite_txn_slice_fifo #(.width(addrWidth + 3), .depth(fifoDepth)) u_aw_fifo (
    .clk(clk), .rst(rst),
    .wr_data({s_awaddr, s_awprot}), .wr_valid(s_awvalid && wr_room), .wr_ready(aw_fifo_ready),
    .rd_data(aw_head), .rd_valid(m_awvalid), .rd_ready(m_awready)
  );
  assign {m_awaddr, m_awprot} = aw_head;

  axi4lite_txn_slice_fifo #(.width(dataWidth + dataWidth/8), .depth(fifoDepth)) u_w_fifo (
    .clk(clk), .rst(rst),
    .wr_data({s_wdata, s_wstrb}), .wr_valid(s_wvalid), .wr_ready(s_wready),
    .rd_data(w_head), .rd_valid(m_wvalid), .rd_ready(m_wready)
  );
  assign {m_wdata, m_wstrb} = w_head;

  axi4lite_txn_slice_fifo #(.width(2), .depth(fifoDepth)) u_b_fifo (
    .clk(clk), .rst(rst),
    .wr_data(m_bresp), .wr_valid(m_bvalid), .wr_ready(m_bready),
    .rd_data(s_bresp), .rd_valid(s_bvalid), .rd_ready(s_bready)
  );

  axi4lite_txn_slice_fifo #(.width(addrWidth + 3), .depth(fifoDepth)) u_ar_fifo (
    .clk(clk), .rst(rst),
    .wr_data({s_araddr, s_arprot}), .wr_valid(s_arvalid && rd_room), .wr_ready(ar_fifo_ready),
    .rd_data(ar_head), .rd_valid(m_arvalid), .rd_ready(m_arready)
  );
  assign {m_araddr, m_arprot} = ar_head;

  axi4lite_txn_slice_fifo #(.width(dataWidth + 2), .depth(fifoDepth)) u_r_fifo (
    .clk(clk), .rst(rst),
    .wr_data({m_rdata, m_rresp}), .wr_valid(m_rvalid), .wr_ready(m_rready),
    .rd_data(r_head), .rd_valid(s_rvalid), .rd_ready(s_rready)
  );
  assign {s_rdata, s_rresp} = r_head;

  // Write outstanding count: request handshake adds, response handshake removes, both cancel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_outstanding <= '0;
    end else if (aw_hs && !b_hs) begin
      wr_outstanding <= wr_outstanding + cntWidth'(1);
    end else if (b_hs && !aw_hs) begin
      wr_outstanding <= wr_outstanding - cntWidth'(1);
    end
  end

  // Read outstanding count, same rule as writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_outstanding <= '0;
    end else if (ar_hs && !r_hs) begin
      rd_outstanding <= rd_outstanding + cntWidth'(1);
    end else if (r_hs && !ar_hs) begin
      rd_outstanding <= rd_outstanding - cntWidth'(1);
    end
  end

  // Error increment for this cycle (0..2) and the saturating next value.
  always_comb begin
    err_inc = {1'b0, (b_hs && (s_bresp != 2'b00))} + {1'b0, (r_hs && (s_rresp != 2'b00))};
    err_sum = {1'b0, err_count} + {15'b0, err_inc};
  end

  // Error counter register, clamped at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count <= '0;
    end else begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
endmodule

// File: doc/axi4lite_txn_slice.md
# axi4lite_txn_slice

Parametrised AXI4-Lite transaction slice that sits between an upstream AXI4-Lite master and a downstream AXI4-Lite slave, such as the APB bridge front-end. All five channels are buffered independently in FIFOs, so reads and writes proceed concurrently and AW/W are decoupled. The number of outstanding write and read transactions is capped per direction. Live outstanding counts and a saturating error-response counter are exported for debug.

## Interface
Parameters:
- dataWidth, 32, data bus width; multiple of 8.
- addrWidth, 32, address bus width.
- fifoDepth, 2, entries per channel FIFO; power of two, ≥2.
- maxOutstanding, 4, maximum accepted-but-unresponded transactions per direction; ≥1.

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- s_awaddr/s_awprot/s_awvalid  in  addrWidth/3/1  upstream write address.
- s_awready  out  1
- s_wdata/s_wstrb/s_wvalid  in  dataWidth/dataWidth/8/1  upstream write data.
- s_wready  out  1
- s_bresp/s_bvalid  out  2/1; s_bready  in  1
- s_araddr/s_arprot/s_arvalid  in  addrWidth/3/1; s_arready  out  1
- s_rdata/s_rresp/s_rvalid  out  dataWidth/2/1; s_rready  in  1
- m_awaddr/m_awprot/m_awvalid  out; m_awready  in
- m_wdata/m_wstrb/m_wvalid  out; m_wready  in
- m_bresp/m_bvalid  in; m_bready  out
- m_araddr/m_arprot/m_arvalid  out; m_arready  in
- m_rdata/m_rresp/m_rvalid  in; m_rready  out
- wr_outstanding  out  $clog2(maxOutstanding+1)  accepted writes awaiting s_b handshake.
- rd_outstanding  out  same width  accepted reads awaiting s_r handshake.
- err_count  out  16  number of non-OKAY responses delivered upstream; saturates at 0xFFFF.

## Operation
- Channel FIFOs:
  - Five synchronous FIFOs: AW, W, AR downstream-bound; B, R upstream-bound.
  - Each FIFO has registered read and write pointers with one extra wrap bit. Full = pointers equal except the MSB; empty = pointers fully equal.
  - Enqueue when producer valid && FIFO ready. Dequeue when consumer valid && ready.
  - The output valid of each FIFO is !empty. Output data is the head entry.
- Ready generation:
  - FIFO input ready = !full. A dequeue in the same cycle does not free space for an enqueue at full.
  - s_awready = !aw_full && (wr_outstanding < maxOutstanding).
  - s_arready = !ar_full && (rd_outstanding < maxOutstanding).
  - s_wready = !w_full. W is not limited by the outstanding count.
  - m_bready = !b_full; m_rready = !r_full.
- Outstanding counters:
  - wr_outstanding +1 on the s_aw handshake and −1 on the s_b handshake; both in the same cycle leaves it unchanged. Same rule for rd_outstanding with s_ar / s_r.
  - Counters never exceed maxOutstanding. An underflow (a response with count 0) cannot occur with a compliant downstream slave. Verification flags it as an assertion failure.
- Error counter: +1 on each s_b handshake with bresp≠2'b00 and on each s_r handshake with rresp≠2'b00. If both occur in one cycle, +2. Saturates at 0xFFFF.
- Ordering: FIFO order within each channel. There is no ID reordering; the AXI4-Lite in-order rule applies.
- Reset (rst=0 at a clock edge):
  - All FIFO pointers, counters and err_count go to 0.
  - All valid outputs (s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid) go to 0. Ready outputs take the empty-FIFO value on the cycle after reset releases.
  - Data outputs go to 0.
  - In-flight transactions are discarded when reset is asserted mid-operation.

## Timing
- Forward latency is 1 cycle. A beat accepted at edge N is visible on the opposite side from edge N+1.
- Throughput is one beat per cycle per channel when fifoDepth ≥ 2 and the consumer is always ready.
- The ready outputs depend only on registered state (pointers, counters). There is no combinational path from any input valid or ready to any output.
- The outstanding limit applies from the cycle after the counter reaches maxOutstanding. s_awready drops at edge N+1 after the handshake that fills the count.
- A response visible upstream at cycle N frees an outstanding slot in the same cycle as its handshake. s_awready can re-assert at edge N+1.

## Test plan
- Reset check: assert rst=0 for 2 cycles.
  - Required: all valids 0, wr/rd_outstanding=0, err_count=0.
  - Required: s_awready=s_wready=s_arready=1 after release.
- Single write: AW addr 0x10, W data 0xDEADBEEF, strb 0xF; downstream accepts immediately and returns bresp=OKAY.
  - Required: m_awaddr=0x10 one cycle later; s_bvalid with bresp=0; wr_outstanding goes 0→1→0.
- Outstanding cap: maxOutstanding=4, m_bvalid held 0, issue 6 AWs.
  - Required: exactly 4 accepted; s_awready=0 afterwards.
  - Then release one B: s_awready=1 the next cycle, and exactly one more AW is accepted.
- FIFO full/backpressure: fifoDepth=2, m_arready=0, push 3 ARs.
  - Required: 2 accepted, s_arready=0.
  - Then m_arready=1: ARs emerge in order with no loss or duplication.
- Concurrent read/write: write and read issued in the same cycle, with responses returned in the same cycle.
  - Required: both complete independently; counters return to 0.
  - Required: with bresp=SLVERR and rresp=DECERR, err_count increments by 2 in one cycle.
- Reset mid-operation: assert rst with 3 writes outstanding and FIFOs non-empty.
  - Required: all state is cleared the next cycle and no stale beat appears on m_* after release.
